// File: rtl/mem_arb.sv
// ---------------------------------------------------------------------------
// mem_arb -- two-master arbiter in front of a single-port synchronous SRAM.
//
// An instruction-fetch port and a data load/store port share one SRAM with
// one-cycle read latency. Grants are combinational from the current requests
// and the registered arbitration state. Data wins on contention, except when
// it has already won STARVE_MAX contended cycles in a row. In that case the
// instruction side is forced through so fetch cannot starve. Every accept
// records a registered owner tag. One cycle later the tag routes the SRAM
// read data (or a write completion) back to the requester that was accepted.
//
// Parameters
//   AW          shared memory word-address width
//   STARVE_MAX  contended data grants allowed in a row before instruction wins
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous reset, active low
//   arb_i_ireq/iaddr    instruction read request, byte address
//   arb_o_igrant        instruction request accepted this cycle
//   arb_o_irvalid/irdata instruction read data, one cycle after accept
//   arb_i_dreq/daddr    data request, byte address
//   arb_i_dwmask/dwdata byte write mask (0 = read), write data
//   arb_o_dgrant        data request accepted this cycle
//   arb_o_drvalid/drdata data completion (read data, or 0 for a write)
//   arb_o_mem_*         SRAM enable, word address, byte mask, write data
//   arb_i_mem_rdata     SRAM read data (valid the cycle after enable)
//   arb_o_halt          fetch stall: instruction requesting but not granted
//   arb_o_conflict_cnt  count of contended cycles
//
// Build option
//   MEM_ARB_PERF_EN     when defined, arb_o_conflict_cnt counts every cycle
//                       in which both requests are high. When undefined, it
//                       is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module mem_arb #(
    parameter int AW         = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arb_i_ireq,
    input  logic [31:0]   arb_i_iaddr,
    output logic          arb_o_igrant,
    output logic          arb_o_irvalid,
    output logic [31:0]   arb_o_irdata,
    input  logic          arb_i_dreq,
    input  logic [31:0]   arb_i_daddr,
    input  logic [3:0]    arb_i_dwmask,
    input  logic [31:0]   arb_i_dwdata,
    output logic          arb_o_dgrant,
    output logic          arb_o_drvalid,
    output logic [31:0]   arb_o_drdata,
    output logic          arb_o_mem_en,
    output logic [AW-1:0] arb_o_mem_addr,
    output logic [3:0]    arb_o_mem_wmask,
    output logic [31:0]   arb_o_mem_wdata,
    input  logic [31:0]   arb_i_mem_rdata,
    output logic          arb_o_halt,
    output logic [31:0]   arb_o_conflict_cnt
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_DRD  = 2'd2,
        OWN_DWR  = 2'd3
    } owner_t;

    owner_t        r_owner_p1;
    owner_t        w_owner_nxt;
    logic [SW-1:0] r_streak;
    logic [SW-1:0] w_streak_nxt;
    logic          w_contend;
    logic          w_starve;
    logic          w_igrant;
    logic          w_dgrant;

    // ---- p0: arbitration, combinational from requests and streak ----
    // While rst is low, every output stays at zero. This includes the
    // outputs that follow the request inputs combinationally, so the grant
    // terms are qualified with rst.
    always_comb begin
        w_contend = arb_i_ireq & arb_i_dreq;
        w_starve  = (r_streak == STREAK_MAX);
        w_igrant  = rst & arb_i_ireq & (~arb_i_dreq | w_starve);
        w_dgrant  = rst & arb_i_dreq & ~w_igrant;
    end

    always_comb begin
        w_owner_nxt  = OWN_NONE;
        w_streak_nxt = r_streak;

        if (w_igrant) begin
            w_owner_nxt = OWN_I;
        end else if (w_dgrant) begin
            w_owner_nxt = (arb_i_dwmask == 4'b0000) ? OWN_DRD : OWN_DWR;
        end

        // The streak counts only contended data wins. Any cycle in which
        // fetch is idle or served clears it.
        if (!arb_i_ireq || w_igrant) begin
            w_streak_nxt = '0;
        end else if (w_dgrant && w_contend && !w_starve) begin
            w_streak_nxt = r_streak + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_p1 <= OWN_NONE;
            r_streak   <= '0;
        end else begin
            r_owner_p1 <= w_owner_nxt;
            r_streak   <= w_streak_nxt;
        end
    end

    assign arb_o_igrant    = w_igrant;
    assign arb_o_dgrant    = w_dgrant;
    assign arb_o_mem_en    = w_igrant | w_dgrant;
    assign arb_o_mem_addr  = w_dgrant ? arb_i_daddr[AW+1:2] :
                             (w_igrant ? arb_i_iaddr[AW+1:2] : '0);
    assign arb_o_mem_wmask = w_dgrant ? arb_i_dwmask : 4'b0000;
    assign arb_o_mem_wdata = rst ? arb_i_dwdata : 32'h0;
    assign arb_o_halt      = rst & arb_i_ireq & ~w_igrant;

    // ---- p1: completion routed by the owner tag of the previous accept ----
    assign arb_o_irvalid = (r_owner_p1 == OWN_I);
    assign arb_o_irdata  = (r_owner_p1 == OWN_I) ? arb_i_mem_rdata : 32'h0;
    assign arb_o_drvalid = (r_owner_p1 == OWN_DRD) || (r_owner_p1 == OWN_DWR);
    assign arb_o_drdata  = (r_owner_p1 == OWN_DRD) ? arb_i_mem_rdata : 32'h0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;

    // Counts contended cycles whether or not a grant occurs. The counter
    // wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= 32'h0;
        end else if (w_contend) begin
            r_conflict_cnt <= r_conflict_cnt + 32'h1;
        end
    end

    assign arb_o_conflict_cnt = r_conflict_cnt;
`else
    assign arb_o_conflict_cnt = 32'h0;
`endif

    // The byte offset and the address bits above the SRAM range are
    // intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{arb_i_iaddr[31:AW+2], arb_i_iaddr[1:0],
                             arb_i_daddr[31:AW+2], arb_i_daddr[1:0]};

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    localparam int AW     = 12;
    localparam int STARVE = 4;
    localparam int DEPTH  = 1 << AW;
`ifdef MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ireq;
    logic [31:0]   iaddr;
    logic          igrant, irvalid;
    logic [31:0]   irdata;
    logic          dreq;
    logic [31:0]   daddr;
    logic [3:0]    dwmask;
    logic [31:0]   dwdata;
    logic          dgrant, drvalid;
    logic [31:0]   drdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          halt;
    logic [31:0]   conflict_cnt;

    always #5 clk = ~clk;

    mem_arb #(.AW(AW), .STARVE_MAX(STARVE)) dut (
        .clk                (clk),
        .rst                (rst),
        .arb_i_ireq         (ireq),
        .arb_i_iaddr        (iaddr),
        .arb_o_igrant       (igrant),
        .arb_o_irvalid      (irvalid),
        .arb_o_irdata       (irdata),
        .arb_i_dreq         (dreq),
        .arb_i_daddr        (daddr),
        .arb_i_dwmask       (dwmask),
        .arb_i_dwdata       (dwdata),
        .arb_o_dgrant       (dgrant),
        .arb_o_drvalid      (drvalid),
        .arb_o_drdata       (drdata),
        .arb_o_mem_en       (mem_en),
        .arb_o_mem_addr     (mem_addr),
        .arb_o_mem_wmask    (mem_wmask),
        .arb_o_mem_wdata    (mem_wdata),
        .arb_i_mem_rdata    (mem_rdata),
        .arb_o_halt         (halt),
        .arb_o_conflict_cnt (conflict_cnt)
    );

    int checks = 0;
    int errors = 0;

    // SRAM behind the DUT, driven only from the DUT's memory outputs.
    logic [31:0] sram    [DEPTH];
    // Reference memory image, updated only by the bench's model.
    logic [31:0] ref_mem [DEPTH];

    // Model state. pend: 0 none, 1 instruction read, 2 data read, 3 data write.
    int          m_pend;
    logic [31:0] m_pend_data;
    int          m_streak;
    int unsigned m_conf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // One clock cycle: called just after a falling edge with the inputs set.
    // exp_gnt: -1 no literal check, 0 no grant, 1 instruction, 2 data.
    task automatic step(input int exp_gnt);
        logic          gi, gd;
        logic [AW-1:0] ea;
        logic          c_en;
        logic [AW-1:0] c_addr;
        logic [3:0]    c_wm;
        logic [31:0]   c_wd;
        #2;
        chk("irvalid", 32'(irvalid), 32'(m_pend == 1));
        chk("irdata", irdata, (m_pend == 1) ? m_pend_data : 32'h0);
        chk("drvalid", 32'(drvalid), 32'(m_pend >= 2));
        chk("drdata", drdata, (m_pend == 2) ? m_pend_data : 32'h0);

        gi = ireq && (!dreq || m_streak == STARVE);
        gd = dreq && !gi;
        ea = gd ? daddr[AW+1:2] : (gi ? iaddr[AW+1:2] : '0);
        chk("igrant", 32'(igrant), 32'(gi));
        chk("dgrant", 32'(dgrant), 32'(gd));
        chk("mem_en", 32'(mem_en), 32'(gi || gd));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wmask", 32'(mem_wmask), gd ? 32'(dwmask) : 32'h0);
        chk("mem_wdata", mem_wdata, dwdata);
        chk("halt", 32'(halt), 32'(ireq && !gi));
        chk("conflict_cnt", conflict_cnt, PERF ? 32'(m_conf) : 32'h0);
        if (exp_gnt >= 0)
            chk("grant_seq", {30'b0, igrant, dgrant},
                (exp_gnt == 1) ? 32'h2 : ((exp_gnt == 2) ? 32'h1 : 32'h0));

        c_en   = mem_en;
        c_addr = mem_addr;
        c_wm   = mem_wmask;
        c_wd   = mem_wdata;

        if (gi) begin
            m_pend      = 1;
            m_pend_data = ref_mem[iaddr[AW+1:2]];
        end else if (gd) begin
            if (dwmask == 4'b0000) begin
                m_pend      = 2;
                m_pend_data = ref_mem[daddr[AW+1:2]];
            end else begin
                m_pend = 3;
                ref_mem[daddr[AW+1:2]] = merge(ref_mem[daddr[AW+1:2]], dwdata, dwmask);
            end
        end else begin
            m_pend = 0;
        end
        if (!ireq || gi) m_streak = 0;
        else if (gd && m_streak < STARVE) m_streak++;
        if (ireq && dreq) m_conf++;

        @(posedge clk);
        if (c_en) begin
            if (c_wm == 4'b0000) mem_rdata = sram[c_addr];
            else sram[c_addr] = merge(sram[c_addr], c_wd, c_wm);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_igrant"}, 32'(igrant), 32'h0);
        chk({tag, "_dgrant"}, 32'(dgrant), 32'h0);
        chk({tag, "_irvalid"}, 32'(irvalid), 32'h0);
        chk({tag, "_drvalid"}, 32'(drvalid), 32'h0);
        chk({tag, "_irdata"}, irdata, 32'h0);
        chk({tag, "_drdata"}, drdata, 32'h0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_halt"}, 32'(halt), 32'h0);
        chk({tag, "_conflict"}, conflict_cnt, 32'h0);
    endtask

    task automatic idle_inputs();
        ireq = 1'b0; dreq = 1'b0; dwmask = 4'b0000;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = 32'hA500_0000 ^ (i * 32'h0001_0003);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0003);
        end
        sram[4]    = 32'h0010_0093;
        ref_mem[4] = 32'h0010_0093;

        rst = 1'b0; ireq = 1'b1; dreq = 1'b1;
        iaddr = 32'h0000_0010; daddr = 32'h0000_0044;
        dwmask = 4'b1111; dwdata = 32'h1234_5678; mem_rdata = 32'h0;
        m_pend = 0; m_pend_data = 32'h0; m_streak = 0; m_conf = 0;

        // Reset state, with both requests high.
        #3;
        check_all_zero("reset");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;

        // Seven contended cycles, then check the conflict count.
        ireq = 1'b1; dreq = 1'b1; dwmask = 4'b0000;
        for (int i = 0; i < 7; i++) step(-1);
        idle_inputs();
        #1 chk("conflict7", conflict_cnt, PERF ? 32'd7 : 32'd0);
        step(0);

        // Instruction read only.
        ireq = 1'b1; iaddr = 32'h0000_0010;
        #1 chk("i_mem_addr", 32'(mem_addr), 32'd4);
        chk("i_halt", 32'(halt), 32'h0);
        step(1);
        idle_inputs();
        #1 chk("i_irvalid", 32'(irvalid), 32'h1);
        chk("i_irdata", irdata, 32'h0010_0093);
        step(0);

        // Data write only.
        dreq = 1'b1; daddr = 32'h0000_0020; dwmask = 4'b0011; dwdata = 32'hDEAD_BEEF;
        #1 chk("w_mem_addr", 32'(mem_addr), 32'd8);
        chk("w_mem_wmask", 32'(mem_wmask), 32'h3);
        step(2);
        idle_inputs();
        #1 chk("w_drvalid", 32'(drvalid), 32'h1);
        chk("w_drdata", drdata, 32'h0);
        step(0);

        // Starvation pattern D,D,D,D,I repeated.
        ireq = 1'b1; iaddr = 32'h0000_0030; dreq = 1'b1; daddr = 32'h0000_0020; dwmask = 4'b0000;
        for (int i = 0; i < 10; i++) step((i % 5 == 4) ? 1 : 2);
        idle_inputs();
        step(0);

        // Alternating instruction and data reads, no bubble.
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            if (k % 2 == 0) begin ireq = 1'b1; iaddr = 32'(k * 4 + 8); end
            else begin dreq = 1'b1; daddr = 32'(k * 4 + 64); end
            step((k % 2 == 0) ? 1 : 2);
        end
        idle_inputs();
        step(0);

        // Reset right after a data read acceptance.
        dreq = 1'b1; daddr = 32'h0000_0040; dwmask = 4'b0000;
        step(2);
        rst = 1'b0;
        ireq = 1'b1; dwmask = 4'b1111; dwdata = 32'hCAFE_F00D;
        #1 check_all_zero("midrst");
        @(posedge clk);
        @(negedge clk);
        #1 chk("midrst_drvalid2", 32'(drvalid), 32'h0);
        chk("midrst_igrant2", 32'(igrant), 32'h0);
        rst = 1'b1;
        m_pend = 0; m_streak = 0; m_conf = 0;
        idle_inputs();
        ireq = 1'b1; iaddr = 32'h0000_0010;
        step(1);
        idle_inputs();
        step(0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ireq   = ($urandom_range(0, 3) != 0);
            dreq   = ($urandom_range(0, 2) != 0);
            iaddr  = 32'($urandom_range(0, 255));
            daddr  = 32'($urandom_range(0, 255));
            dwmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            dwdata = $urandom;
            step(-1);
        end
        idle_inputs();
        step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
